// File: rtl/dtfag_idx_gen.sv
// ============================================================================
// Module      : dtfag_idx_gen
// Description : Radix-16 (i,t,j) index sweep generator driving the twiddle-ROM
//               read enable of the DTFAG address stage.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef RADIX_WIDTH
`define RADIX_WIDTH 4
`endif

`default_nettype none

module dtfag_idx_gen #(
    parameter int RADIX_W = `RADIX_WIDTH,
    parameter int CNT_W   = 3*RADIX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   cfg_last,
    input  logic               stall,
    output logic [RADIX_W-1:0] DTFAG_i,
    output logic [RADIX_W-1:0] DTFAG_t,
    output logic [RADIX_W-1:0] DTFAG_j,
    output logic               ROM_CEN_in,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last;
    logic             r_fin;
    logic             r_cen;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // r_cnt holds the last issued index, so the digits are simply its slices.
    assign DTFAG_j    = r_cnt[RADIX_W-1:0];
    assign DTFAG_t    = r_cnt[2*RADIX_W-1:RADIX_W];
    assign DTFAG_i    = r_cnt[3*RADIX_W-1:2*RADIX_W];
    assign ROM_CEN_in = r_cen;
    assign busy       = r_busy;
    assign done       = r_done;

    // r_fin marks that the final index has been issued; the counter is never
    // advanced past it, so a full 0..FFF sweep cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= '0;
            r_fin   <= 1'b0;
            r_cen   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_cen  <= 1'b1;
                    if (start) begin
                        r_last  <= cfg_last;
                        r_cnt   <= '0;
                        r_fin   <= (cfg_last == '0);
                        r_cen   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_fin) begin
                        r_fin   <= 1'b0;
                        r_cen   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (stall) begin
                        r_cen <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        r_cen <= 1'b0;
                        r_fin <= (w_cnt_inc == r_last);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_cen   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_fin   <= 1'b0;
                    r_cen   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
